// File: rtl/uartcon_hexfmt_if.sv
// Handshake bundle between the hex formatter, its word source and the debug UART transmitter.
// The master side drives words and load pulses; the formatter sits on the slave side.
interface uartcon_hexfmt_if #(
  parameter int unsigned NIBBLES = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   in_data;
  logic                   busy;
  logic                   tx_valid;
  logic                   tx_load;
  logic [7:0]             tx_data;

  modport master (
    output in_valid,
    output in_data,
    output tx_load,
    input  in_ready,
    input  busy,
    input  tx_valid,
    input  tx_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  tx_load,
    output in_ready,
    output busy,
    output tx_valid,
    output tx_data
  );
endinterface

// File: rtl/uartcon_hexfmt.sv
// Converts a debug word to ASCII hex characters (MS nibble first, optional CR LF) and presents
// them one at a time to the debug UART transmitter on a level-valid / load-pulse interface.
module uartcon_hexfmt #(
  parameter int unsigned NIBBLES   = 8,
  parameter bit          ADD_CRLF  = 1'b1,
  parameter bit          UPPERCASE = 1'b1
) (
  input logic            clk,
  input logic            rst,
  uartcon_hexfmt_if.slave bus
);

  localparam int unsigned        DataW  = 4 * NIBBLES;
  localparam int unsigned        CntW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0]    CntTop = CntW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StHex, StCr, StLf} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [DataW-1:0]  word_q, word_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              finish;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [DataW-1:0] word, input logic [CntW-1:0] idx);
    logic [DataW-1:0] shifted;
    shifted = word >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

  assign cnt_dec = cnt_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    finish     = 1'b0;

    case (state_q)
      StIdle: begin
        // Raising in_ready here gives the one-cycle ready delay after reset release.
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          word_d     = bus.in_data;
          cnt_d      = CntTop;
          state_d    = StHex;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = hex_char(nibble_at(bus.in_data, CntTop));
        end
      end
      StHex: begin
        if (bus.tx_load) begin
          if (cnt_q != '0) begin
            cnt_d     = cnt_dec;
            tx_data_d = hex_char(nibble_at(word_q, cnt_dec));
          end else if (ADD_CRLF) begin
            state_d   = StCr;
            tx_data_d = 8'h0D;
          end else begin
            finish = 1'b1;
          end
        end
      end
      StCr: begin
        if (bus.tx_load) begin
          state_d   = StLf;
          tx_data_d = 8'h0A;
        end
      end
      StLf: begin
        if (bus.tx_load) begin
          finish = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // tx_data deliberately keeps the last character after the line completes.
    if (finish) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      in_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uartcon_hexfmt.sv
// Bench for uartcon_hexfmt: a default instance and a 2-digit lowercase no-CRLF instance, driven
// through one shared stimulus set and checked against a character-queue reference model.
module tb_uartcon_hexfmt;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uartcon_hexfmt_if #(.NIBBLES(8)) bus ();
  uartcon_hexfmt_if #(.NIBBLES(2)) bus2 ();

  uartcon_hexfmt #(.NIBBLES(8), .ADD_CRLF(1'b1), .UPPERCASE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uartcon_hexfmt #(.NIBBLES(2), .ADD_CRLF(1'b0), .UPPERCASE(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // sel routes the shared stimulus to one instance and picks which outputs are observed.
  logic        sel;
  logic        iv;
  logic        tl;
  logic [31:0] idat;

  assign bus.in_valid  = iv & ~sel;
  assign bus.in_data   = idat;
  assign bus.tx_load   = tl & ~sel;
  assign bus2.in_valid = iv & sel;
  assign bus2.in_data  = idat[7:0];
  assign bus2.tx_load  = tl & sel;

  logic       o_ready, o_busy, o_valid;
  logic [7:0] o_data;
  assign o_ready = sel ? bus2.in_ready : bus.in_ready;
  assign o_busy  = sel ? bus2.busy     : bus.busy;
  assign o_valid = sel ? bus2.tx_valid : bus.tx_valid;
  assign o_data  = sel ? bus2.tx_data  : bus.tx_data;

  int vectors = 0;
  int miscompares = 0;
  byte unsigned exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected character line for a word, from the hex/ASCII rules of the selected instance.
  task automatic build(input logic [31:0] w);
    int  n;
    bit  crlf;
    bit  up;
    int  d;
    n    = sel ? 2 : 8;
    crlf = !sel;
    up   = !sel;
    exp_q.delete();
    for (int i = n - 1; i >= 0; i--) begin
      d = int'((w >> (4 * i)) & 32'hF);
      if (d < 10) exp_q.push_back(8'(48 + d));
      else        exp_q.push_back(8'((up ? 65 : 97) + d - 10));
    end
    if (crlf) begin
      exp_q.push_back(8'd13);
      exp_q.push_back(8'd10);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input logic [31:0] w, input bit hold, input bit load_too);
    int n = 0;
    iv   = 1'b1;
    idat = w;
    tl   = load_too;
    while (o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 200), 32'd1);
    @(negedge clk);
    tl = 1'b0;
    if (!hold) iv = 1'b0;
    build(w);
  endtask

  // Transmitter model: waits gmin..gmax cycles per character, then pulses tx_load once.
  task automatic drain(input int gmin, input int gmax, input int nmax);
    byte unsigned c = 0;
    int k = 0;
    while (exp_q.size() > 0 && k < nmax) begin
      c = exp_q.pop_front();
      check("tx_valid", o_valid, 1);
      check("tx_data", o_data, c);
      check("busy", o_busy, 1);
      check("in_ready_busy", o_ready, 0);
      repeat ($urandom_range(gmax, gmin)) begin
        @(negedge clk);
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, c);
      end
      tl = 1'b1;
      @(negedge clk);
      tl = 1'b0;
      k++;
    end
    if (exp_q.size() == 0) begin
      check("end_valid", o_valid, 0);
      check("end_busy", o_busy, 0);
      check("end_ready", o_ready, 1);
      check("end_data", o_data, c);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    sel  = 1'b0;
    iv   = 1'b0;
    tl   = 1'b0;
    idat = 32'h0;
    @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.tx_valid, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst2_ready", bus2.in_ready, 0);
    check("rst2_data", bus2.tx_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", o_ready, 1);

    // Fixed one-cycle transmitter latency.
    accept(32'h1234ABCD, 1'b0, 1'b0);
    drain(1, 1, 100);

    // Loads in idle are ignored, including one coinciding with the accept edge.
    tl = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_load_valid", o_valid, 0);
      check("idle_load_data", o_data, 8'h0A);
      check("idle_load_ready", o_ready, 1);
    end
    tl = 1'b0;
    accept(32'hC0FFEE42, 1'b0, 1'b1);
    drain(0, 3, 100);

    // in_valid held across two words; the second waits for the first to finish.
    accept(32'h00000000, 1'b1, 1'b0);
    idat = 32'hFFFFFFFF;
    drain(0, 4, 100);
    accept(32'hFFFFFFFF, 1'b0, 1'b0);
    drain(0, 4, 100);

    // Random words and long random transmitter gaps.
    for (int i = 0; i < 5; i++) begin
      accept($urandom, 1'b0, 1'b0);
      drain(0, 50, 100);
    end

    // Asynchronous reset mid-word abandons the line.
    accept(32'hDEADBEEF, 1'b0, 1'b0);
    drain(0, 2, 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_data", o_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", o_ready, 1);
    check("post_rst_valid", o_valid, 0);
    accept(32'h00000001, 1'b0, 1'b0);
    drain(0, 2, 100);

    // Two-digit lowercase instance without CR LF.
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    check("n2_idle_ready", o_ready, 1);
    accept(32'h000000FE, 1'b0, 1'b0);
    drain(1, 1, 100);
    for (int i = 0; i < 6; i++) begin
      accept(32'($urandom_range(255, 0)), 1'b0, 1'b0);
      drain(0, 20, 100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
